rpn_stack_master: RTL and testbench
===================================

Name: rpn_stack_master

Overview:
Command-side initiator for the team's hardware stack (Push/Pop/Top/DataOut/Full/Empty/Error interface).
- Accepts a stream of reverse-Polish tokens over a valid/ready handshake: operands and operators.
- Sequences one stack command per cycle to evaluate the tokens, and reports results and underflow/overflow errors.
- Sits between a token source (decoder/CPU port) and one stack instance of matching WIDTH/ADDRESS_BITS.

Parameters:
WIDTH, 8, data bits; must match the stack.
ADDRESS_BITS, 10, stack address bits; must match the stack.
DEPTH, 1 << ADDRESS_BITS, stack capacity in entries.

Ports:
Clk  in  1  single clock; all logic on rising edge.
Reset  in  1  synchronous, active-high; also drives the stack's reset.
TokValid  in  1  token present.
TokReady  out  1  block can accept a token.
TokIsOp  in  1  1 = operator token, 0 = operand token.
TokOp  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 DUP, 6 DROP, 7 PEEK.
TokData  in  WIDTH  operand value; ignored for operators.
Result  out  WIDTH  result of the last ALU op, DUP or PEEK.
ResultValid  out  1  one-cycle pulse: Result is valid.
TokErr  out  1  one-cycle pulse: token rejected.
StkErrSticky  out  1  set when StkError is sampled high; cleared only by Reset.
Count  out  ADDRESS_BITS+1  shadow entry count, 0..DEPTH.
StkPush, StkPop, StkTop  out  1 each  stack commands; at most one high per cycle.
StkEnable  out  1  constant 1 when not in Reset.
StkDataIn  out  WIDTH  push data.
StkDataOut  in  WIDTH  stack read data; valid the cycle after a Pop/Top command.
StkFull, StkEmpty, StkError  in  1 each  stack status.

Behaviour:
- Reset (synchronous):
  - FSM goes to IDLE; Count=0.
  - Result=0, ResultValid=0, TokErr=0, StkErrSticky=0.
  - All Stk* commands 0; StkDataIn=0.
- Handshake:
  - TokReady=1 only in IDLE.
  - A transfer occurs when TokValid && TokReady are both high on a clock edge.
- Outputs: all outputs are registered or decoded from the state register only; none depend combinationally on token inputs.
- Token legality is checked against Count at acceptance:
  - Operand: needs Count<DEPTH.
  - ADD/SUB/AND/OR/XOR: need Count>=2.
  - DUP: needs 1<=Count<DEPTH.
  - DROP/PEEK: need Count>=1.
- Illegal token: consumed; TokErr pulses the next cycle; no stack command issued; Count unchanged; FSM stays IDLE.
- Count is updated at acceptance: operand +1, binary op -1, DUP +1, DROP -1, PEEK 0.
- FSM states: IDLE, PUSH, POPB, POPA, CAPA, TOP, CAPT, EMIT.
  - Operand: IDLE -> PUSH (StkPush=1, StkDataIn=operand) -> IDLE. Accepted at cycle t; TokReady again at t+2.
  - Binary op: IDLE -> POPB (StkPop) -> POPA (StkPop; B <= StkDataOut) -> CAPA (A <= StkDataOut; ResReg <= A op B) -> PUSH (StkPush, StkDataIn=ResReg, ResultValid=1, Result=ResReg) -> IDLE. TokReady again at t+5.
  - SUB computes A-B, where A is the deeper entry; result is modulo 2^WIDTH with no carry out. ADD wraps the same way.
  - DUP: IDLE -> TOP (StkTop) -> CAPT (ResReg <= StkDataOut) -> PUSH -> IDLE. ResultValid pulses in PUSH.
  - DROP: IDLE -> POPB -> IDLE. No result.
  - PEEK: IDLE -> TOP -> CAPT -> EMIT (ResultValid=1, Result=ResReg) -> IDLE.
- Boundaries:
  - Count==DEPTH: operand/DUP rejected, so the stack never receives a push while full.
  - Count==0: all pops/tops rejected.
  - Binary op at Count==DEPTH is legal: the push follows two pops.
  - StkError high on any edge sets StkErrSticky. It indicates shadow/stack divergence and is an assertion target. Nothing else reacts to it.
  - StkFull/StkEmpty are not used for legality; the bench checks StkEmpty==(Count==0) and StkFull==(Count==DEPTH) whenever the FSM is in IDLE.
- Reset mid-sequence: FSM aborts to IDLE and Count=0; the stack must be reset by the same edge, so no partial result is pushed.

Decomposition:
- Shared package rpn_pkg holds:
  - opcode constants OP_ADD..OP_PEEK;
  - FSM state encodings;
  - the function alu_op(op, a, b) returning WIDTH bits.
- One natural sub-module: rpn_alu, combinational, WIDTH-parameterised; inputs opcode, A, B; output result.
- The FSM and the Count register stay in the top level.

Test Plan:
- ADDRESS_BITS=2 (DEPTH 4).
  - Operands 5, 3 then SUB -> ResultValid with Result=2; Count=1; a following PEEK gives Result=2.
  - Operands 2, 7 then SUB -> Result=251 (wrap); operands 200, 100 then ADD -> Result=44.
  - Operand 9 then DUP then ADD -> Result=18; Count=1; StkEmpty=0.
  - Four operands 1..4 -> Count=4, StkFull=1. A fifth operand -> TokErr pulse, no StkPush, Count=4. ADD -> Result=7, Count=3.
- Empty stack:
  - DROP -> TokErr, no StkPop.
  - Single operand 6 then XOR -> TokErr, Count=1.
  - PEEK on that stack -> Result=6.
- Back-to-back and reset behaviour:
  - TokValid held high with 8 tokens -> each accepted only when TokReady=1.
  - Reset asserted during POPA -> next cycle IDLE, Count=0, StkErrSticky=0, no StkPush.
  - StkErrSticky stays 0 throughout all scenarios.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack master.
// Holds the operator opcodes, the sequencer state encoding and the ALU
// function used by rpn_alu. No ports; imported by the other files.
package rpn_pkg;

  // Widest operand the shared ALU function handles; callers truncate the
  // result back to their own WIDTH. ADD/SUB wrap correctly because the low
  // bits of a wider add/subtract equal the narrow modulo result.
  localparam int ALU_MAX_W = 64;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_DROP = 3'd6;
  localparam logic [2:0] OP_PEEK = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PUSH = 3'd1,
    ST_POPB = 3'd2,
    ST_POPA = 3'd3,
    ST_CAPA = 3'd4,
    ST_TOP  = 3'd5,
    ST_CAPT = 3'd6,
    ST_EMIT = 3'd7
  } state_t;

  // Binary operators only; a is the deeper stack entry, so SUB is a - b.
  // Non-binary opcodes return zero.
  function automatic logic [ALU_MAX_W-1:0] alu_op(
    input logic [2:0]           op,
    input logic [ALU_MAX_W-1:0] a,
    input logic [ALU_MAX_W-1:0] b
  );
    logic [ALU_MAX_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN stack master.
// Ports:
//   opcode - operator code (ADD/SUB/AND/OR/XOR meaningful)
//   a      - deeper operand (first pushed)
//   b      - top-of-stack operand
//   result - a op b, modulo 2^WIDTH
import rpn_pkg::*;

module rpn_alu #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = WIDTH'(alu_op(opcode, ALU_MAX_W'(a), ALU_MAX_W'(b)));
  end

endmodule

// File: rtl/rpn_stack_master.sv
// RPN stack master: accepts operand/operator tokens over a valid/ready
// handshake and drives one external hardware stack, one command per cycle.
// Ports:
//   Clk, Reset                  - clock, synchronous active-high reset
//   TokValid/TokReady           - token handshake
//   TokIsOp, TokOp, TokData     - token contents
//   Result, ResultValid         - last ALU/DUP/PEEK result and its pulse
//   TokErr                      - pulse: token rejected (illegal for Count)
//   StkErrSticky                - latched StkError, cleared by Reset
//   Count                       - shadow entry count, 0..DEPTH
//   StkPush/StkPop/StkTop       - stack commands
//   StkEnable, StkDataIn        - stack enable and push data
//   StkDataOut                  - stack read data, valid cycle after Pop/Top
//   StkFull/StkEmpty/StkError   - stack status
import rpn_pkg::*;

module rpn_stack_master #(
  parameter int WIDTH        = 8,
  parameter int ADDRESS_BITS = 10
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    TokValid,
  output logic                    TokReady,
  input  logic                    TokIsOp,
  input  logic [2:0]              TokOp,
  input  logic [WIDTH-1:0]        TokData,
  output logic [WIDTH-1:0]        Result,
  output logic                    ResultValid,
  output logic                    TokErr,
  output logic                    StkErrSticky,
  output logic [ADDRESS_BITS:0]   Count,
  output logic                    StkPush,
  output logic                    StkPop,
  output logic                    StkTop,
  output logic                    StkEnable,
  output logic [WIDTH-1:0]        StkDataIn,
  input  logic [WIDTH-1:0]        StkDataOut,
  input  logic                    StkFull,
  input  logic                    StkEmpty,
  input  logic                    StkError
);

  localparam int DEPTH = 1 << ADDRESS_BITS;
  localparam logic [ADDRESS_BITS:0] CNT_DEPTH = (ADDRESS_BITS+1)'(DEPTH);
  localparam logic [ADDRESS_BITS:0] CNT_ONE   = (ADDRESS_BITS+1)'(1);
  localparam logic [ADDRESS_BITS:0] CNT_TWO   = (ADDRESS_BITS+1)'(2);

  state_t state, state_next;

  logic [ADDRESS_BITS:0] count;
  logic [2:0]            op_reg;
  logic [WIDTH-1:0]      b_reg;
  logic [WIDTH-1:0]      res_reg;
  logic [WIDTH-1:0]      push_data;
  logic                  push_is_result;
  logic                  tok_err_reg;
  logic                  sticky;
  logic                  accept;
  logic                  legal;
  logic [WIDTH-1:0]      alu_result;

  // Legality is judged against the shadow count, never StkFull/StkEmpty,
  // so the status inputs are intentionally left unread.
  logic unused_status;
  assign unused_status = StkFull | StkEmpty;

  assign accept = TokValid && (state == ST_IDLE);

  // The top of stack is B (popped first), the entry below it is A.
  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode (op_reg),
    .a      (StkDataOut),
    .b      (b_reg),
    .result (alu_result)
  );

  always_comb begin
    legal = 1'b0;
    if (!TokIsOp) begin
      legal = (count < CNT_DEPTH);
    end else begin
      case (TokOp)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: legal = (count >= CNT_TWO);
        OP_DUP:  legal = (count != '0) && (count < CNT_DEPTH);
        default: legal = (count != '0);
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept && legal) begin
          if (!TokIsOp) begin
            state_next = ST_PUSH;
          end else if (TokOp == OP_DUP || TokOp == OP_PEEK) begin
            state_next = ST_TOP;
          end else begin
            state_next = ST_POPB;
          end
        end
      end
      ST_POPB: state_next = (op_reg == OP_DROP) ? ST_IDLE : ST_POPA;
      ST_POPA: state_next = ST_CAPA;
      ST_CAPA: state_next = ST_PUSH;
      ST_PUSH: state_next = ST_IDLE;
      ST_TOP:  state_next = ST_CAPT;
      ST_CAPT: state_next = (op_reg == OP_PEEK) ? ST_EMIT : ST_PUSH;
      ST_EMIT: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decode only the state register and datapath registers. Commands
  // are also held off while Reset is high so the stack sees nothing partial.
  always_comb begin
    TokReady    = (state == ST_IDLE);
    StkPush     = 1'b0;
    StkPop      = 1'b0;
    StkTop      = 1'b0;
    StkDataIn   = '0;
    ResultValid = 1'b0;
    if (!Reset) begin
      case (state)
        ST_PUSH: begin
          StkPush     = 1'b1;
          StkDataIn   = push_data;
          ResultValid = push_is_result;
        end
        ST_POPB, ST_POPA: StkPop      = 1'b1;
        ST_TOP:           StkTop      = 1'b1;
        ST_EMIT:          ResultValid = 1'b1;
        default: ;
      endcase
    end
  end

  assign StkEnable    = !Reset;
  assign Result       = res_reg;
  assign TokErr       = tok_err_reg;
  assign StkErrSticky = sticky;
  assign Count        = count;

  // Count moves at acceptance so the next token is judged against the
  // post-command depth even while the current command is still in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count          <= '0;
      op_reg         <= OP_ADD;
      b_reg          <= '0;
      res_reg        <= '0;
      push_data      <= '0;
      push_is_result <= 1'b0;
      tok_err_reg    <= 1'b0;
      sticky         <= 1'b0;
    end else begin
      tok_err_reg <= 1'b0;
      if (StkError) begin
        sticky <= 1'b1;
      end
      if (accept) begin
        if (legal) begin
          op_reg         <= TokOp;
          push_data      <= TokData;
          push_is_result <= TokIsOp;
          if (!TokIsOp) begin
            count <= count + CNT_ONE;
          end else begin
            case (TokOp)
              OP_DUP:  count <= count + CNT_ONE;
              OP_PEEK: count <= count;
              default: count <= count - CNT_ONE;
            endcase
          end
        end else begin
          tok_err_reg <= 1'b1;
        end
      end
      case (state)
        ST_POPA: b_reg <= StkDataOut;
        ST_CAPA: begin
          res_reg   <= alu_result;
          push_data <= alu_result;
        end
        ST_CAPT: begin
          res_reg   <= StkDataOut;
          push_data <= StkDataOut;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_master.sv
// Bench for rpn_stack_master with a behavioural stack and an RPN reference
// model that queues expected results for the output monitor.
import rpn_pkg::*;

module tb_rpn_stack_master;

  localparam int WIDTH = 8;
  localparam int AB    = 2;
  localparam int DEPTH = 4;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             TokValid = 1'b0;
  logic             TokReady;
  logic             TokIsOp = 1'b0;
  logic [2:0]       TokOp = 3'd0;
  logic [WIDTH-1:0] TokData = '0;
  logic [WIDTH-1:0] Result;
  logic             ResultValid;
  logic             TokErr;
  logic             StkErrSticky;
  logic [AB:0]      Count;
  logic             StkPush, StkPop, StkTop, StkEnable;
  logic [WIDTH-1:0] StkDataIn;
  logic [WIDTH-1:0] StkDataOut;
  logic             StkFull, StkEmpty, StkError;

  int tests_run = 0;
  int fails = 0;
  int exp_errs = 0, got_errs = 0;
  int push_cnt = 0, pop_cnt = 0, top_cnt = 0;
  logic [WIDTH-1:0] ms[$];
  logic [WIDTH-1:0] exp_q[$];

  rpn_stack_master #(.WIDTH(WIDTH), .ADDRESS_BITS(AB)) dut (
    .Clk(Clk), .Reset(Reset), .TokValid(TokValid), .TokReady(TokReady),
    .TokIsOp(TokIsOp), .TokOp(TokOp), .TokData(TokData), .Result(Result),
    .ResultValid(ResultValid), .TokErr(TokErr), .StkErrSticky(StkErrSticky),
    .Count(Count), .StkPush(StkPush), .StkPop(StkPop), .StkTop(StkTop),
    .StkEnable(StkEnable), .StkDataIn(StkDataIn), .StkDataOut(StkDataOut),
    .StkFull(StkFull), .StkEmpty(StkEmpty), .StkError(StkError)
  );

  always #5 Clk = ~Clk;

  // Behavioural stack: data out is registered, valid the cycle after Pop/Top.
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  int sp;
  always @(posedge Clk) begin
    if (Reset) begin
      sp         <= 0;
      StkDataOut <= '0;
      StkError   <= 1'b0;
    end else begin
      StkError <= 1'b0;
      if (StkEnable && StkPush) begin
        if (sp >= DEPTH) StkError <= 1'b1;
        else begin mem[sp] <= StkDataIn; sp <= sp + 1; end
      end else if (StkEnable && StkPop) begin
        if (sp == 0) StkError <= 1'b1;
        else begin StkDataOut <= mem[sp-1]; sp <= sp - 1; end
      end else if (StkEnable && StkTop) begin
        if (sp == 0) StkError <= 1'b1;
        else StkDataOut <= mem[sp-1];
      end
    end
  end
  assign StkFull  = (sp == DEPTH);
  assign StkEmpty = (sp == 0);

  // Output monitor: scoreboard pops on every ResultValid, status checked in IDLE.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (TokErr) got_errs++;
      if (StkPush) push_cnt++;
      if (StkPop) pop_cnt++;
      if (StkTop) top_cnt++;
      if (ResultValid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_result: got %0d, none expected", Result);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          if (Result !== e) begin
            fails++;
            $display("[TB] FAIL result: got %0d, expected %0d", Result, e);
          end
        end
      end
      if (TokReady === 1'b1) begin
        tests_run++;
        if (StkEmpty !== (Count == 3'd0) || StkFull !== (Count == 3'(DEPTH)) ||
            StkErrSticky !== 1'b0) begin
          fails++;
          $display("[TB] FAIL idle_status: Count=%0d Empty=%b Full=%b Sticky=%b, expected Empty=%b Full=%b Sticky=0",
                   Count, StkEmpty, StkFull, StkErrSticky, (Count == 3'd0), (Count == 3'(DEPTH)));
        end
      end
      if (int'(StkPush) + int'(StkPop) + int'(StkTop) > 1) begin
        tests_run++;
        fails++;
        $display("[TB] FAIL one_command: push=%b pop=%b top=%b, expected at most one", StkPush, StkPop, StkTop);
      end
    end
  end

  function automatic void model_token(input logic is_op, input logic [2:0] op,
                                      input logic [WIDTH-1:0] data);
    logic [WIDTH-1:0] a, b, r;
    int n;
    n = ms.size();
    if (!is_op) begin
      if (n < DEPTH) ms.push_back(data); else exp_errs++;
    end else if (op <= OP_XOR) begin
      if (n >= 2) begin
        b = ms.pop_back();
        a = ms.pop_back();
        case (op)
          OP_ADD:  r = a + b;
          OP_SUB:  r = a - b;
          OP_AND:  r = a & b;
          OP_OR:   r = a | b;
          default: r = a ^ b;
        endcase
        ms.push_back(r);
        exp_q.push_back(r);
      end else exp_errs++;
    end else if (op == OP_DUP) begin
      if (n >= 1 && n < DEPTH) begin
        r = ms[n-1];
        ms.push_back(r);
        exp_q.push_back(r);
      end else exp_errs++;
    end else if (op == OP_DROP) begin
      if (n >= 1) r = ms.pop_back(); else exp_errs++;
    end else begin
      if (n >= 1) exp_q.push_back(ms[n-1]); else exp_errs++;
    end
  endfunction

  task automatic do_reset();
    TokValid = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    ms.delete();
    exp_q.delete();
    #1;
  endtask

  task automatic send_token(input logic is_op, input logic [2:0] op, input logic [WIDTH-1:0] data);
    int guard = 0;
    while (TokReady !== 1'b1 && guard < 40) begin @(negedge Clk); guard++; end
    tests_run++;
    if (TokReady !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_timeout: TokReady=%b, expected 1", TokReady);
      return;
    end
    TokIsOp = is_op; TokOp = op; TokData = data; TokValid = 1'b1;
    model_token(is_op, op, data);
    @(posedge Clk);
    @(negedge Clk);
    TokValid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge Clk);
    while (TokReady !== 1'b1 && guard < 40) begin @(negedge Clk); guard++; end
    tests_run++;
    if (TokReady !== 1'b1) begin
      fails++;
      $display("[TB] FAIL idle_timeout: TokReady=%b, expected 1", TokReady);
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (Count !== 3'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d, expected 0", Count); end
    tests_run++; if (Result !== 8'd0) begin fails++; $display("[TB] FAIL reset_result: got %0d, expected 0", Result); end
    tests_run++; if (ResultValid !== 1'b0 || TokErr !== 1'b0 || StkErrSticky !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_flags: rv=%b err=%b sticky=%b, expected 0 0 0", ResultValid, TokErr, StkErrSticky); end
    tests_run++; if ({StkPush, StkPop, StkTop} !== 3'b000 || StkDataIn !== 8'd0) begin
      fails++; $display("[TB] FAIL reset_cmds: cmds=%b data=%0d, expected 000 0", {StkPush, StkPop, StkTop}, StkDataIn); end
    tests_run++; if (TokReady !== 1'b1 || StkEnable !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_ready: ready=%b enable=%b, expected 1 1", TokReady, StkEnable); end
  endtask

  task automatic test_sub_peek();
    do_reset();
    send_token(1'b0, 3'd0, 8'd5);
    send_token(1'b0, 3'd0, 8'd3);
    send_token(1'b1, OP_SUB, 8'd0);
    wait_idle();
    tests_run++; if (Result !== 8'd2) begin fails++; $display("[TB] FAIL sub_result: got %0d, expected 2", Result); end
    tests_run++; if (Count !== 3'd1) begin fails++; $display("[TB] FAIL sub_count: got %0d, expected 1", Count); end
    send_token(1'b1, OP_PEEK, 8'd0);
    wait_idle();
    tests_run++; if (Result !== 8'd2) begin fails++; $display("[TB] FAIL peek_result: got %0d, expected 2", Result); end
  endtask

  task automatic test_wrap();
    do_reset();
    send_token(1'b0, 3'd0, 8'd2);
    send_token(1'b0, 3'd0, 8'd7);
    send_token(1'b1, OP_SUB, 8'd0);
    wait_idle();
    tests_run++; if (Result !== 8'd251) begin fails++; $display("[TB] FAIL sub_wrap: got %0d, expected 251", Result); end
    send_token(1'b0, 3'd0, 8'd200);
    send_token(1'b0, 3'd0, 8'd100);
    send_token(1'b1, OP_ADD, 8'd0);
    wait_idle();
    tests_run++; if (Result !== 8'd44) begin fails++; $display("[TB] FAIL add_wrap: got %0d, expected 44", Result); end
    tests_run++; if (Count !== 3'd2) begin fails++; $display("[TB] FAIL wrap_count: got %0d, expected 2", Count); end
  endtask

  task automatic test_dup();
    do_reset();
    send_token(1'b0, 3'd0, 8'd9);
    send_token(1'b1, OP_DUP, 8'd0);
    send_token(1'b1, OP_ADD, 8'd0);
    wait_idle();
    tests_run++; if (Result !== 8'd18) begin fails++; $display("[TB] FAIL dup_add: got %0d, expected 18", Result); end
    tests_run++; if (Count !== 3'd1 || StkEmpty !== 1'b0) begin
      fails++; $display("[TB] FAIL dup_count: Count=%0d Empty=%b, expected 1 0", Count, StkEmpty); end
  endtask

  task automatic test_full();
    int pushes, errs;
    do_reset();
    for (int i = 1; i <= 4; i++) send_token(1'b0, 3'd0, 8'(i));
    wait_idle();
    tests_run++; if (Count !== 3'd4 || StkFull !== 1'b1) begin
      fails++; $display("[TB] FAIL full_count: Count=%0d Full=%b, expected 4 1", Count, StkFull); end
    pushes = push_cnt; errs = got_errs;
    send_token(1'b0, 3'd0, 8'd5);
    wait_idle();
    tests_run++; if (got_errs - errs !== 1) begin fails++; $display("[TB] FAIL full_tokerr: got %0d pulses, expected 1", got_errs - errs); end
    tests_run++; if (push_cnt - pushes !== 0 || Count !== 3'd4) begin
      fails++; $display("[TB] FAIL full_nopush: pushes=%0d Count=%0d, expected 0 4", push_cnt - pushes, Count); end
    send_token(1'b1, OP_ADD, 8'd0);
    wait_idle();
    tests_run++; if (Result !== 8'd7 || Count !== 3'd3) begin
      fails++; $display("[TB] FAIL full_add: Result=%0d Count=%0d, expected 7 3", Result, Count); end
  endtask

  task automatic test_empty();
    int pops, errs;
    do_reset();
    pops = pop_cnt; errs = got_errs;
    send_token(1'b1, OP_DROP, 8'd0);
    wait_idle();
    tests_run++; if (got_errs - errs !== 1 || pop_cnt - pops !== 0) begin
      fails++; $display("[TB] FAIL empty_drop: errs=%0d pops=%0d, expected 1 0", got_errs - errs, pop_cnt - pops); end
    send_token(1'b0, 3'd0, 8'd6);
    send_token(1'b1, OP_XOR, 8'd0);
    wait_idle();
    tests_run++; if (got_errs - errs !== 2 || Count !== 3'd1) begin
      fails++; $display("[TB] FAIL single_xor: errs=%0d Count=%0d, expected 2 1", got_errs - errs, Count); end
    send_token(1'b1, OP_PEEK, 8'd0);
    wait_idle();
    tests_run++; if (Result !== 8'd6) begin fails++; $display("[TB] FAIL empty_peek: got %0d, expected 6", Result); end
  endtask

  task automatic test_back_to_back();
    logic       is_op [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] ops   [8] = '{3'd0, 3'd0, OP_ADD, OP_DUP, 3'd0, OP_SUB, OP_PEEK, OP_DROP};
    logic [7:0] vals  [8] = '{8'd10, 8'd20, 8'd0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd0};
    int pushes, pops, tops;
    do_reset();
    pushes = push_cnt; pops = pop_cnt; tops = top_cnt;
    TokValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int guard = 0;
      TokIsOp = is_op[i]; TokOp = ops[i]; TokData = vals[i];
      while (TokReady !== 1'b1 && guard < 40) begin @(negedge Clk); guard++; end
      model_token(is_op[i], ops[i], vals[i]);
      @(negedge Clk);
      tests_run++;
      if (TokReady !== 1'b0) begin fails++; $display("[TB] FAIL b2b_busy[%0d]: TokReady=%b, expected 0", i, TokReady); end
    end
    TokValid = 1'b0;
    wait_idle();
    tests_run++; if (push_cnt - pushes !== 6 || pop_cnt - pops !== 5 || top_cnt - tops !== 2) begin
      fails++; $display("[TB] FAIL b2b_cmds: push=%0d pop=%0d top=%0d, expected 6 5 2",
                        push_cnt - pushes, pop_cnt - pops, top_cnt - tops); end
    tests_run++; if (Count !== 3'd1 || Result !== 8'd25) begin
      fails++; $display("[TB] FAIL b2b_final: Count=%0d Result=%0d, expected 1 25", Count, Result); end
  endtask

  task automatic test_reset_mid();
    int pushes;
    do_reset();
    send_token(1'b0, 3'd0, 8'd5);
    send_token(1'b0, 3'd0, 8'd3);
    wait_idle();
    pushes = push_cnt;
    send_token(1'b1, OP_SUB, 8'd0);
    @(negedge Clk);
    tests_run++; if (StkPop !== 1'b1 || TokReady !== 1'b0) begin
      fails++; $display("[TB] FAIL mid_popa: pop=%b ready=%b, expected 1 0", StkPop, TokReady); end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    ms.delete();
    exp_q.delete();
    #1;
    tests_run++; if (Count !== 3'd0 || TokReady !== 1'b1 || StkErrSticky !== 1'b0) begin
      fails++; $display("[TB] FAIL mid_reset: Count=%0d ready=%b sticky=%b, expected 0 1 0", Count, TokReady, StkErrSticky); end
    repeat (4) @(negedge Clk);
    #1;
    tests_run++; if (push_cnt - pushes !== 0 || ResultValid !== 1'b0) begin
      fails++; $display("[TB] FAIL mid_nopush: pushes=%0d rv=%b, expected 0 0", push_cnt - pushes, ResultValid); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_sub_peek();
    test_wrap();
    test_dup();
    test_full();
    test_empty();
    test_back_to_back();
    test_reset_mid();
    tests_run++; if (got_errs !== exp_errs) begin
      fails++; $display("[TB] FAIL tokerr_total: got %0d, expected %0d", got_errs, exp_errs); end
    tests_run++; if (exp_q.size() != 0) begin
      fails++; $display("[TB] FAIL pending_results: got %0d left, expected 0", exp_q.size()); end
    tests_run++; if (StkErrSticky !== 1'b0) begin
      fails++; $display("[TB] FAIL sticky_final: got %b, expected 0", StkErrSticky); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
